// File: rtl/detecto_pkg.sv
// Shared types and constants for the Sobel edge-detection stream.
package detecto_pkg;

  localparam int DEF_WIDTH   = 768;
  localparam int DEF_HEIGHT  = 512;
  localparam int DEF_COORD_W = 11;

  typedef logic [7:0]             pixel_t;
  typedef logic [DEF_COORD_W-1:0] coord_t;

  // Rec.601-style luma weights; they sum to 256 so the result never exceeds 255.
  localparam logic [15:0] LUMA_R     = 16'd77;
  localparam logic [15:0] LUMA_G     = 16'd150;
  localparam logic [15:0] LUMA_B     = 16'd29;
  localparam int          LUMA_SHIFT = 8;

  localparam int SOBEL_LATENCY = 4;

  // Weighted RGB sum kept to 16 bits, then scaled back to 8-bit gray.
  function automatic pixel_t luma(input pixel_t r, input pixel_t g, input pixel_t b);
    logic [15:0] sum;
    sum = LUMA_R * {8'd0, r} + LUMA_G * {8'd0, g} + LUMA_B * {8'd0, b};
    return pixel_t'(sum >> LUMA_SHIFT);
  endfunction

  // Zero-extends a pixel into the signed gradient width.
  function automatic logic signed [10:0] widen(input pixel_t p);
    return $signed({3'b000, p});
  endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// One image row of 8-bit pixels; synchronous read that returns the old
// contents when the same address is written on the same edge.
module sobel_line_buffer
  import detecto_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  localparam int AW    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic          clk,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output pixel_t        rd_data,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  pixel_t        wr_data
);

  pixel_t mem [0:WIDTH-1];

  // Read and write share the edge; non-blocking semantics give read-before-write.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

endmodule

// File: rtl/sobel_stream.sv
// Streaming Sobel edge detector: luma, 3x3 window from two line buffers,
// gradients, then saturated (or thresholded) magnitude at the window centre.
module sobel_stream
  import detecto_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int HEIGHT  = DEF_HEIGHT,
  parameter int COORD_W = DEF_COORD_W,
  parameter int THRESH  = 0
) (
  input  logic               CAMERA_CLK,
  input  logic               rst_n,
  input  logic               pixel_valid,
  input  logic [7:0]         in_R,
  input  logic [7:0]         in_G,
  input  logic [7:0]         in_B,
  input  logic [COORD_W-1:0] in_X,
  input  logic [COORD_W-1:0] in_Y,
  output logic               out_valid,
  output logic [7:0]         out_pix,
  output logic [COORD_W-1:0] out_X,
  output logic [COORD_W-1:0] out_Y
);

  localparam int                 AW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [COORD_W-1:0] X_LIM    = COORD_W'(WIDTH);
  localparam logic [COORD_W-1:0] Y_LIM    = COORD_W'(HEIGHT);
  localparam logic [COORD_W-1:0] ONE      = COORD_W'(1);
  localparam logic [11:0]        THRESH_V = 12'(THRESH);

  logic armed, frame_start, in_range, accept;

  logic               v1;
  pixel_t             gray1;
  logic [COORD_W-1:0] x1, y1;

  logic               v2;
  pixel_t             gray2, rd0, rd1;
  logic [COORD_W-1:0] x2, y2;

  logic               v3;
  logic [COORD_W-1:0] x3, y3;
  pixel_t             win [0:2][0:2];

  logic               v4;
  logic [COORD_W-1:0] x4, y4;
  logic signed [10:0] gx4, gy4;

  logic signed [10:0] gx_c, gy_c;
  logic [10:0]        ax, ay;
  logic [11:0]        mag;
  pixel_t             edge_val;
  logic               emit, border;

  assign frame_start = (in_X == '0) && (in_Y == '0);
  assign in_range    = (in_X < X_LIM) && (in_Y < Y_LIM);
  assign accept      = pixel_valid && in_range && (armed || frame_start);

  // Input is ignored until the first frame start seen after reset.
  always_ff @(posedge CAMERA_CLK or negedge rst_n) begin
    if (!rst_n) begin
      armed <= 1'b0;
    end else if (pixel_valid && frame_start) begin
      armed <= 1'b1;
    end
  end

  // Stage 1: convert the accepted pixel to gray and capture its coordinates.
  always_ff @(posedge CAMERA_CLK or negedge rst_n) begin
    if (!rst_n) begin
      v1    <= 1'b0;
      gray1 <= '0;
      x1    <= '0;
      y1    <= '0;
    end else begin
      v1 <= accept;
      if (accept) begin
        gray1 <= luma(in_R, in_G, in_B);
        x1    <= in_X;
        y1    <= in_Y;
      end
    end
  end

  // Row Y-1 lives in lb0; its old contents cascade into lb1 as row Y-2.
  sobel_line_buffer #(.WIDTH(WIDTH)) u_lb0 (
    .clk     (CAMERA_CLK),
    .rd_en   (v1),
    .rd_addr (x1[AW-1:0]),
    .rd_data (rd0),
    .wr_en   (v1),
    .wr_addr (x1[AW-1:0]),
    .wr_data (gray1)
  );

  // lb1 is written one stage later because its data is lb0's registered read.
  sobel_line_buffer #(.WIDTH(WIDTH)) u_lb1 (
    .clk     (CAMERA_CLK),
    .rd_en   (v1),
    .rd_addr (x1[AW-1:0]),
    .rd_data (rd1),
    .wr_en   (v2),
    .wr_addr (x2[AW-1:0]),
    .wr_data (rd0)
  );

  // Stage 2: carry gray and coordinates alongside the line-buffer reads.
  always_ff @(posedge CAMERA_CLK or negedge rst_n) begin
    if (!rst_n) begin
      v2    <= 1'b0;
      gray2 <= '0;
      x2    <= '0;
      y2    <= '0;
    end else begin
      v2 <= v1;
      if (v1) begin
        gray2 <= gray1;
        x2    <= x1;
        y2    <= y1;
      end
    end
  end

  // Stage 3: shift the 3x3 window left and load the new right column.
  always_ff @(posedge CAMERA_CLK or negedge rst_n) begin
    if (!rst_n) begin
      v3 <= 1'b0;
      x3 <= '0;
      y3 <= '0;
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win[r][c] <= '0;
        end
      end
    end else begin
      v3 <= v2;
      if (v2) begin
        x3 <= x2;
        y3 <= y2;
        for (int r = 0; r < 3; r++) begin
          win[r][0] <= win[r][1];
          win[r][1] <= win[r][2];
        end
        win[0][2] <= rd1;
        win[1][2] <= rd0;
        win[2][2] <= gray2;
      end
    end
  end

  // Horizontal and vertical Sobel kernels over the current window.
  always_comb begin
    gx_c = (widen(win[0][2]) + (widen(win[1][2]) <<< 1) + widen(win[2][2]))
         - (widen(win[0][0]) + (widen(win[1][0]) <<< 1) + widen(win[2][0]));
    gy_c = (widen(win[2][0]) + (widen(win[2][1]) <<< 1) + widen(win[2][2]))
         - (widen(win[0][0]) + (widen(win[0][1]) <<< 1) + widen(win[0][2]));
  end

  // Stage 4: register gradients with the coordinates of the newest column.
  always_ff @(posedge CAMERA_CLK or negedge rst_n) begin
    if (!rst_n) begin
      v4  <= 1'b0;
      x4  <= '0;
      y4  <= '0;
      gx4 <= '0;
      gy4 <= '0;
    end else begin
      v4 <= v3;
      if (v3) begin
        x4  <= x3;
        y4  <= y3;
        gx4 <= gx_c;
        gy4 <= gy_c;
      end
    end
  end

  // Magnitude, saturation or binarisation, and border/emit decisions.
  always_comb begin
    ax  = gx4[10] ? 11'(-gx4) : 11'(gx4);
    ay  = gy4[10] ? 11'(-gy4) : 11'(gy4);
    mag = {1'b0, ax} + {1'b0, ay};
    if (THRESH > 0) begin
      edge_val = (mag >= THRESH_V) ? 8'hFF : 8'h00;
    end else begin
      edge_val = (mag > 12'd255) ? 8'hFF : mag[7:0];
    end
    emit   = (x4 != '0) && (y4 != '0);
    border = (x4 == ONE) || (y4 == ONE);
  end

  // Output register; the centre sits one row and one column behind the input.
  always_ff @(posedge CAMERA_CLK or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_pix   <= '0;
      out_X     <= '0;
      out_Y     <= '0;
    end else begin
      out_valid <= v4 && emit;
      if (v4 && emit) begin
        out_pix <= border ? 8'h00 : edge_val;
        out_X   <= x4 - ONE;
        out_Y   <= y4 - ONE;
      end
    end
  end

endmodule
